// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin selection function for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned MAX_NREQ = 16;
  localparam int unsigned MAX_IDXW = 4;
  localparam int unsigned CANDW    = MAX_IDXW + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_IDXW-1:0] idx;
  } rr_sel_t;

  // First set bit of req scanning upward from ptr with wrap at nreq; ptr wins ties.
  function automatic rr_sel_t rr_next(input logic [MAX_NREQ-1:0] req,
                                      input logic [MAX_IDXW-1:0] ptr,
                                      input int unsigned         nreq);
    rr_sel_t          sel;
    logic [CANDW-1:0] cand;
    sel = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      cand = {1'b0, ptr} + CANDW'(i);
      if (cand >= CANDW'(nreq)) cand = cand - CANDW'(nreq);
      if ((i < nreq) && !sel.found && req[cand[MAX_IDXW-1:0]]) begin
        sel.found = 1'b1;
        sel.idx   = cand[MAX_IDXW-1:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: index, one-hot and found flag for the next owner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    found_c,
  output logic [$clog2(NREQ)-1:0] idx_c,
  output logic [NREQ-1:0]         onehot_c
);

  localparam int unsigned IDXW = $clog2(NREQ);

  rr_sel_t sel;

  assign sel     = rr_next(MAX_NREQ'(req), MAX_IDXW'(ptr), NREQ);
  assign found_c = sel.found;

  // Decode the wide selection back to this instance's requester range.
  always_comb begin
    idx_c    = '0;
    onehot_c = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (sel.idx == MAX_IDXW'(j)) begin
        idx_c       = IDXW'(j);
        onehot_c[j] = sel.found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between NREQ producers in bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ack,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [NREQ-1:0]       grant,
  output logic                  busy
);

  localparam int unsigned IDXW = $clog2(NREQ);
  localparam int unsigned CNTW = $clog2(BURST + 1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

  logic             pick_found;
  logic [IDXW-1:0]  pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic             owner_req;
  logic [DSIZE-1:0] owner_data;
  logic             burst_done;

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx),
    .onehot_c(pick_onehot)
  );

  // Mux out the current owner's request and data word.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IDXW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign burst_done = (beat_cnt_q == CNTW'(BURST - 1));

  // Next-state and write-strobe logic; writes are gated by wfull and by reset.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    winc       = 1'b0;
    wdata      = '0;
    req_ack    = '0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          grant_d    = pick_onehot;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        winc    = owner_req & ~wfull & ~wrst;
        wdata   = owner_data;
        req_ack = grant_q & {NREQ{winc}};
        if (winc) beat_cnt_d = beat_cnt_q + CNTW'(1);
        if ((winc && burst_done) || !owner_req) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          ptr_d      = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + IDXW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == GRANT);

endmodule
